fc_rx_framer: RTL



---
 rtl/fc_rx_framer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/fc_rx_framer.sv
// Receive-side FC frame delineator: hunts SOF, strips SOF/EOF, emits content as Avalon-ST
// packets with CRC/length/code-error status and saturating good/bad frame counters.
module fc_rx_framer #(
  parameter int unsigned MAX_WORDS = 537,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      in_data,
  input  logic [3:0]       in_datak,
  input  logic             in_valid,
  input  logic             in_codeerr,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_startofpacket,
  output logic             out_endofpacket,
  output logic [2:0]       out_error,
  output logic [7:0]       out_sof_type,
  output logic [7:0]       out_eof_type,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_bad
);

  localparam int unsigned     CntW    = $clog2(MAX_WORDS + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_WORDS);
  localparam logic [31:0]     CrcPoly = 32'h04C1_1DB7;
  localparam logic [31:0]     CrcInit = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {StHunt, StFrame, StDiscard} state_e;

  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CrcPoly;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  state_e          r_state;
  logic [31:0]     r_crc;
  logic [31:0]     r_crc_prev;
  logic [31:0]     r_hold;
  logic            r_have_hold;
  logic            r_started;
  logic [CntW-1:0] r_cnt;
  logic            r_codeerr;
  logic [7:0]      r_sof_type;
  logic            r_nobeat;

  logic [31:0]     r_out_data;
  logic            r_out_valid;
  logic            r_out_sop;
  logic            r_out_eop;
  logic [2:0]      r_out_err;
  logic [7:0]      r_out_sof;
  logic [7:0]      r_out_eof;
  logic [CNT_W-1:0] r_frames_ok;
  logic [CNT_W-1:0] r_frames_bad;

  logic        w_os, w_sof, w_eof, w_data, w_drop, w_absorb;
  logic [2:0]  w_eof_err;
  logic        w_emit, w_eop, w_nobeat;
  logic [2:0]  w_err;
  logic [7:0]  w_eof_type;

  assign w_os   = (in_datak == 4'b1000) && (in_data[31:24] == 8'hBC);
  assign w_sof  = w_os && (in_data[23:16] == 8'hB5);
  assign w_eof  = w_os && ((in_data[23:16] == 8'h95) || (in_data[23:16] == 8'h8A));
  assign w_data = (in_datak == 4'b0000);
  // A non-eop beat refused by the sink poisons the rest of the packet.
  assign w_drop = r_out_valid && !out_ready && !r_out_eop;
  assign w_absorb = (r_state == StFrame) && in_valid && w_data && (r_cnt != MaxCnt) && !w_drop;
  assign w_eof_err = {r_codeerr | in_codeerr,
                      (r_cnt < CntW'(2)) | w_drop,
                      r_crc_prev != ~r_hold};

  always_comb begin
    w_emit     = 1'b0;
    w_eop      = 1'b0;
    w_nobeat   = 1'b0;
    w_err      = 3'b000;
    w_eof_type = 8'h00;
    if (r_state == StFrame) begin
      if (w_absorb) begin
        w_emit = r_have_hold;
      end else begin
        // Every other input closes the frame; only a real EOF carries its type and CRC check.
        w_emit   = r_have_hold;
        w_eop    = r_have_hold;
        w_nobeat = !r_have_hold;
        if (r_have_hold) begin
          if (in_valid && w_eof) begin
            w_err      = w_eof_err;
            w_eof_type = in_data[23:16];
          end else begin
            w_err = {r_codeerr, 1'b1, 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StHunt;
      r_crc       <= CrcInit;
      r_crc_prev  <= CrcInit;
      r_hold      <= '0;
      r_have_hold <= 1'b0;
      r_started   <= 1'b0;
      r_cnt       <= '0;
      r_codeerr   <= 1'b0;
      r_sof_type  <= 8'h00;
      r_nobeat    <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_err   <= 3'b000;
      r_out_sof   <= 8'h00;
      r_out_eof   <= 8'h00;
    end else begin
      r_out_valid <= w_emit;
      r_out_sop   <= w_emit && !r_started;
      r_out_eop   <= w_eop;
      r_out_err   <= w_err;
      r_out_eof   <= w_eof_type;
      r_nobeat    <= w_nobeat;
      if (w_emit) begin
        r_out_data <= r_hold;
        r_out_sof  <= r_sof_type;
      end

      if (in_valid && w_sof) begin
        // SOF opens a new frame from any state (after the old one was closed above).
        r_state     <= StFrame;
        r_sof_type  <= in_data[23:16];
        r_crc       <= CrcInit;
        r_crc_prev  <= CrcInit;
        r_have_hold <= 1'b0;
        r_started   <= 1'b0;
        r_cnt       <= '0;
        r_codeerr   <= in_codeerr;
      end else begin
        case (r_state)
          StFrame: begin
            if (w_absorb) begin
              r_crc_prev  <= r_crc;
              r_crc       <= crc32_word(r_crc, in_data);
              r_hold      <= in_data;
              r_have_hold <= 1'b1;
              r_started   <= r_started | r_have_hold;
              r_cnt       <= r_cnt + CntW'(1);
              r_codeerr   <= r_codeerr | in_codeerr;
            end else if (in_valid && w_data) begin
              r_state <= StDiscard;
            end else begin
              r_state <= StHunt;
            end
          end
          StDiscard: begin
            if (in_valid && w_eof) r_state <= StHunt;
          end
          default: r_state <= StHunt;
        endcase
      end
    end
  end

  logic             w_closed, w_ok_inc, w_bad_inc;
  logic [CNT_W:0]   w_ok_sum, w_bad_sum;

  // A closed packet counts as good only if its eop beat was error-free and accepted.
  assign w_closed  = r_out_valid && r_out_eop;
  assign w_ok_inc  = w_closed && out_ready && (r_out_err == 3'b000);
  assign w_bad_inc = w_closed && !w_ok_inc;
  assign w_ok_sum  = {1'b0, r_frames_ok} + (CNT_W + 1)'(w_ok_inc);
  assign w_bad_sum = {1'b0, r_frames_bad} + (CNT_W + 1)'(w_bad_inc) + (CNT_W + 1)'(r_nobeat);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frames_ok  <= '0;
      r_frames_bad <= '0;
    end else begin
      r_frames_ok  <= w_ok_sum[CNT_W]  ? '1 : w_ok_sum[CNT_W-1:0];
      r_frames_bad <= w_bad_sum[CNT_W] ? '1 : w_bad_sum[CNT_W-1:0];
    end
  end

  assign out_data          = r_out_data;
  assign out_valid         = r_out_valid;
  assign out_startofpacket = r_out_sop;
  assign out_endofpacket   = r_out_eop;
  assign out_error         = r_out_err;
  assign out_sof_type      = r_out_sof;
  assign out_eof_type      = r_out_eof;
  assign frames_ok         = r_frames_ok;
  assign frames_bad        = r_frames_bad;

endmodule
